// File: rtl/br_sched_pkg.sv
// Shared types and constants for the round-robin binary scheduler.
// The optional stall counter is enabled by macro BR_SCHED_RR_BIN_STALL_CNT_EN.
package br_sched_pkg;

  localparam int unsigned StallCntWidth = 16;

  typedef enum logic {
    SchedIdle  = 1'b0,
    SchedGrant = 1'b1
  } sched_state_e;

endpackage

// File: rtl/br_enc_bin2onehot.sv
// Binary index to one-hot decoder; output is all-zero when in_valid is low.
module br_enc_bin2onehot #(
  parameter int unsigned NumOut   = 4,
  parameter int unsigned BinWidth = $clog2(NumOut)
) (
  input  logic                in_valid,
  input  logic [BinWidth-1:0] in_bin,
  output logic [NumOut-1:0]   out_onehot
);

  always_comb begin
    out_onehot = '0;
    for (int unsigned i = 0; i < NumOut; i++) begin
      if (in_valid && (in_bin == BinWidth'(i))) begin
        out_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_sched_rr_bin.sv
// Round-robin scheduler with per-winner bursts, ready/valid grant and binary + one-hot winner.
// Define BR_SCHED_RR_BIN_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
module br_sched_rr_bin
  import br_sched_pkg::*;
#(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned MaxBurst      = 2,
  parameter int unsigned BinWidth      = $clog2(NumRequesters)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NumRequesters-1:0] req,
  output logic                     grant_valid,
  input  logic                     grant_ready,
  output logic [BinWidth-1:0]      grant_bin,
  output logic [NumRequesters-1:0] grant_onehot,
  output logic                     grant_last
`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
  ,
  output logic [StallCntWidth-1:0] stall_cnt
`endif
);

  localparam int unsigned BurstCntWidth = $clog2(MaxBurst + 1);
  localparam logic [BurstCntWidth-1:0] LastCnt = BurstCntWidth'(MaxBurst - 1);
  localparam logic SingleBurst = (MaxBurst == 32'd1);

  if (NumRequesters < 2) begin : g_chk_num_req
    $error("NumRequesters must be at least 2");
  end
  if (MaxBurst < 1) begin : g_chk_max_burst
    $error("MaxBurst must be at least 1");
  end
  if (BinWidth < $clog2(NumRequesters)) begin : g_chk_bin_width
    $error("BinWidth too narrow for NumRequesters");
  end

  sched_state_e               state_q, state_d;
  logic [BinWidth-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BurstCntWidth-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BinWidth-1:0]        grant_bin_q, grant_bin_d;
  logic                       grant_last_q, grant_last_d;

  logic [BinWidth-1:0]        next_ptr_c;
  logic [BinWidth-1:0]        search_ptr_c;
  logic [NumRequesters-1:0]   rot_req_c;
  logic                       found_c;
  logic [BinWidth-1:0]        pick_c;
  logic                       win_req_c;

  assign grant_valid = (state_q == SchedGrant);
  assign grant_bin   = grant_bin_q;
  assign grant_last  = grant_last_q;

  br_enc_bin2onehot #(
    .NumOut  (NumRequesters),
    .BinWidth(BinWidth)
  ) u_enc (
    .in_valid  (grant_valid),
    .in_bin    (grant_bin_q),
    .out_onehot(grant_onehot)
  );

  // On acceptance the search starts just past the current winner; in IDLE from rr_ptr.
  assign next_ptr_c   = (grant_bin_q == BinWidth'(NumRequesters - 1)) ? '0
                                                                      : grant_bin_q + BinWidth'(1);
  assign search_ptr_c = (state_q == SchedIdle) ? rr_ptr_q : next_ptr_c;
  assign rot_req_c    = NumRequesters'({req, req} >> search_ptr_c);
  assign win_req_c    = |(req & grant_onehot);

  always_comb begin
    int unsigned p;
    found_c = 1'b0;
    pick_c  = search_ptr_c;
    p       = 0;
    for (int unsigned i = 0; i < NumRequesters; i++) begin
      if (!found_c && rot_req_c[i]) begin
        found_c = 1'b1;
        p = 32'(search_ptr_c) + i;
        if (p >= NumRequesters) begin
          p = p - NumRequesters;
        end
        pick_c = BinWidth'(p);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    grant_bin_d  = grant_bin_q;
    grant_last_d = grant_last_q;
    case (state_q)
      SchedIdle: begin
        if (found_c) begin
          state_d      = SchedGrant;
          grant_bin_d  = pick_c;
          burst_cnt_d  = '0;
          grant_last_d = SingleBurst;
        end
      end
      SchedGrant: begin
        if (grant_ready) begin
          if (!grant_last_q && win_req_c) begin
            burst_cnt_d  = burst_cnt_q + BurstCntWidth'(1);
            grant_last_d = (burst_cnt_d == LastCnt);
          end else begin
            rr_ptr_d    = next_ptr_c;
            burst_cnt_d = '0;
            if (found_c) begin
              grant_bin_d  = pick_c;
              grant_last_d = SingleBurst;
            end else begin
              state_d      = SchedIdle;
              grant_last_d = 1'b0;
            end
          end
        end
      end
      default: state_d = SchedIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SchedIdle;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      grant_bin_q  <= '0;
      grant_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      grant_bin_q  <= grant_bin_d;
      grant_last_q <= grant_last_d;
    end
  end

`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
  logic [StallCntWidth-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (grant_valid && !grant_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + StallCntWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  a_bin_in_range: assert property (@(posedge clk) disable iff (rst)
    grant_valid |-> (32'(grant_bin) < NumRequesters));

endmodule

// File: tb/tb_br_sched_rr_bin.sv
// Bench for br_sched_rr_bin: directed scenarios on three configurations plus a randomized run
// against a behavioural round-robin model.
module tb_br_sched_rr_bin;

  logic       clk;
  logic       rst;

  logic [3:0] req_a;
  logic       ready_a;
  logic       gv_a;
  logic [1:0] gb_a;
  logic [3:0] go_a;
  logic       gl_a;

  logic [3:0] req_b;
  logic       ready_b;
  logic       gv_b;
  logic [1:0] gb_b;
  logic [3:0] go_b;
  logic       gl_b;

  logic [2:0] req_c;
  logic       ready_c;
  logic       gv_c;
  logic [1:0] gb_c;
  logic [2:0] go_c;
  logic       gl_c;

`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
  logic [15:0] sc_a;
  logic [15:0] sc_b;
  logic [15:0] sc_c;
`endif

  int checks;
  int failures;

  br_sched_rr_bin #(.NumRequesters(4), .MaxBurst(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .grant_valid(gv_a), .grant_ready(ready_a),
    .grant_bin(gb_a), .grant_onehot(go_a), .grant_last(gl_a)
`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
    , .stall_cnt(sc_a)
`endif
  );

  br_sched_rr_bin #(.NumRequesters(4), .MaxBurst(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .grant_valid(gv_b), .grant_ready(ready_b),
    .grant_bin(gb_b), .grant_onehot(go_b), .grant_last(gl_b)
`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
    , .stall_cnt(sc_b)
`endif
  );

  br_sched_rr_bin #(.NumRequesters(3), .MaxBurst(2)) u_dut_c (
    .clk(clk), .rst(rst), .req(req_c), .grant_valid(gv_c), .grant_ready(ready_c),
    .grant_bin(gb_c), .grant_onehot(go_c), .grant_last(gl_c)
`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
    , .stall_cnt(sc_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First requester at or after 'from' going round the ring; -1 if none.
  function automatic int rr_find(logic [3:0] r, int from);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (from + k) % 4;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
    tick();
    tick();
    checks++;
    if ({gv_a, gb_a, go_a, gl_a} !== 8'd0) begin
      failures++;
      $display("FAIL reset_a: valid=%0b bin=%0d onehot=%b last=%0b expected all zero", gv_a, gb_a, go_a, gl_a);
    end
    checks++;
    if ({gv_b, go_b, gv_c, go_c} !== 9'd0) begin
      failures++;
      $display("FAIL reset_bc: b valid=%0b onehot=%b c valid=%0b onehot=%b expected zero", gv_b, go_b, gv_c, go_c);
    end
    rst = 1'b0;
    req_a = 4'b0100;
    tick();
    checks++;
    if (gv_a !== 1'b1 || gb_a !== 2'd2) begin
      failures++;
      $display("FAIL pre_rst_grant: valid=%0b bin=%0d expected 1/2", gv_a, gb_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gv_a !== 1'b0 || go_a !== 4'd0) begin
      failures++;
      $display("FAIL async_rst: valid=%0b onehot=%b expected 0/0000", gv_a, go_a);
    end
    tick();
    checks++;
    if (gv_a !== 1'b0 || go_a !== 4'd0) begin
      failures++;
      $display("FAIL rst_next_cycle: valid=%0b onehot=%b expected 0/0000", gv_a, go_a);
    end
    rst = 1'b0;
    req_a = 4'b1000;
    tick();
    checks++;
    if (gv_a !== 1'b1 || gb_a !== 2'd3 || go_a !== 4'b1000 || gl_a !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_grant: valid=%0b bin=%0d onehot=%b last=%0b expected 1/3/1000/0",
               gv_a, gb_a, go_a, gl_a);
    end
    req_a = 4'b0000;
    ready_a = 1'b1;
    tick();
    checks++;
    if (gv_a !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_idle: valid=%0b expected 0", gv_a);
    end
    ready_a = 1'b0;
  endtask

  task automatic test_round_robin();
    req_b = 4'b1111;
    ready_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gv_b !== 1'b1 || gb_b !== 2'(i % 4) || gl_b !== 1'b1 || go_b !== 4'(1 << (i % 4))) begin
        failures++;
        $display("FAIL rr_seq[%0d]: valid=%0b bin=%0d last=%0b onehot=%b expected 1/%0d/1/%b",
                 i, gv_b, gb_b, gl_b, go_b, i % 4, 4'(1 << (i % 4)));
      end
    end
    req_b = 4'b0000;
    tick();
    checks++;
    if (gv_b !== 1'b0 || go_b !== 4'd0) begin
      failures++;
      $display("FAIL rr_idle: valid=%0b onehot=%b expected 0/0000", gv_b, go_b);
    end
    ready_b = 1'b0;
  endtask

  task automatic test_burst();
    logic [1:0] exp_bin [5];
    logic       exp_last [5];
    exp_bin  = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    req_a = 4'b0101;
    ready_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gv_a !== 1'b1 || gb_a !== exp_bin[i] || gl_a !== exp_last[i]) begin
        failures++;
        $display("FAIL burst[%0d]: valid=%0b bin=%0d last=%0b expected 1/%0d/%0b",
                 i, gv_a, gb_a, gl_a, exp_bin[i], exp_last[i]);
      end
    end
    req_a = 4'b0000;
    tick();
    checks++;
    if (gv_a !== 1'b0) begin
      failures++;
      $display("FAIL burst_idle: valid=%0b expected 0", gv_a);
    end
    ready_a = 1'b0;
  endtask

  task automatic test_backpressure();
    req_a = 4'b0010;
    ready_a = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) req_a = 4'b0000;
      checks++;
      if (gv_a !== 1'b1 || gb_a !== 2'd1 || go_a !== 4'b0010 || gl_a !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%0b bin=%0d onehot=%b last=%0b expected 1/1/0010/0",
                 c, gv_a, gb_a, go_a, gl_a);
      end
      tick();
    end
    req_a = 4'b1101;
    ready_a = 1'b1;
    tick();
    checks++;
    if (gv_a !== 1'b1 || gb_a !== 2'd2) begin
      failures++;
      $display("FAIL bp_ptr: valid=%0b bin=%0d expected 1/2", gv_a, gb_a);
    end
    req_a = 4'b0000;
    tick();
    ready_a = 1'b0;
  endtask

  task automatic test_wrap_idle();
    req_c = 3'b010;
    ready_c = 1'b0;
    tick();
    checks++;
    if (gv_c !== 1'b1 || gb_c !== 2'd1) begin
      failures++;
      $display("FAIL wrap_setup: valid=%0b bin=%0d expected 1/1", gv_c, gb_c);
    end
    req_c = 3'b000;
    ready_c = 1'b1;
    tick();
    req_c = 3'b001;
    ready_c = 1'b0;
    tick();
    checks++;
    if (gv_c !== 1'b1 || gb_c !== 2'd0 || go_c !== 3'b001) begin
      failures++;
      $display("FAIL wrap_grant: valid=%0b bin=%0d onehot=%b expected 1/0/001", gv_c, gb_c, go_c);
    end
    req_c = 3'b000;
    ready_c = 1'b1;
    tick();
    checks++;
    if (gv_c !== 1'b0 || go_c !== 3'b000) begin
      failures++;
      $display("FAIL wrap_idle: valid=%0b onehot=%b expected 0/000", gv_c, go_c);
    end
    ready_c = 1'b0;
  endtask

  task automatic test_random();
    int busy, win, cnt, ptr, w;
    rst = 1'b1;
    req_a = '0;
    ready_a = 1'b0;
    tick();
    rst = 1'b0;
    busy = 0; win = 0; cnt = 0; ptr = 0;
    for (int n = 0; n < 500; n++) begin
      req_a = 4'($urandom_range(0, 15));
      ready_a = ($urandom_range(0, 3) != 0);
      if (busy == 0) begin
        w = rr_find(req_a, ptr);
        if (w >= 0) begin
          busy = 1; win = w; cnt = 0;
        end
      end else if (ready_a) begin
        if (cnt < 1 && (((req_a >> win) & 4'd1) != 4'd0)) begin
          cnt++;
        end else begin
          ptr = (win + 1) % 4;
          cnt = 0;
          w = rr_find(req_a, ptr);
          if (w >= 0) win = w;
          else busy = 0;
        end
      end
      tick();
      checks++;
      if (busy != 0) begin
        if (gv_a !== 1'b1 || gb_a !== 2'(win) || go_a !== 4'(1 << win) || gl_a !== (cnt == 1)) begin
          failures++;
          $display("FAIL rand[%0d]: valid=%0b bin=%0d onehot=%b last=%0b expected 1/%0d/%b/%0b",
                   n, gv_a, gb_a, go_a, gl_a, win, 4'(1 << win), (cnt == 1));
        end
      end else if (gv_a !== 1'b0 || go_a !== 4'd0) begin
        failures++;
        $display("FAIL rand[%0d]: valid=%0b onehot=%b expected 0/0000", n, gv_a, go_a);
      end
    end
    req_a = '0;
    ready_a = 1'b1;
    tick();
    tick();
    ready_a = 1'b0;
  endtask

`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (sc_a !== 16'd0) begin
      failures++;
      $display("FAIL stall_reset: stall_cnt=%0d expected 0", sc_a);
    end
    req_a = 4'b0001;
    ready_a = 1'b0;
    for (int n = 0; n < 11; n++) tick();
    checks++;
    if (sc_a !== 16'd10) begin
      failures++;
      $display("FAIL stall_early: stall_cnt=%0d expected 10", sc_a);
    end
    for (int n = 0; n < 70000; n++) tick();
    checks++;
    if (sc_a !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_sat: stall_cnt=%h expected ffff", sc_a);
    end
    for (int n = 0; n < 5; n++) tick();
    checks++;
    if (sc_a !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_hold: stall_cnt=%h expected ffff", sc_a);
    end
    req_a = '0;
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
    test_reset();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_wrap_idle();
    test_random();
`ifdef BR_SCHED_RR_BIN_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/br_sched_rr_bin.md
BR_SCHED_RR_BIN -- requirements
Module: br_sched_rr_bin

Interface
REQ-001 The block SHALL have parameter NumRequesters, default 4, meaning the number of requesters; it SHALL be at least 2.
REQ-002 The block SHALL have parameter MaxBurst, default 2, meaning the maximum number of back-to-back grants to one requester; it SHALL be at least 1.
REQ-003 The block SHALL have parameter BinWidth, default $clog2(NumRequesters), meaning the binary index width; it SHALL be at least $clog2(NumRequesters).
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning reset; reset is asynchronous and active-high.
REQ-006 The block SHALL have port req, input, NumRequesters bits, meaning level-sensitive requests, one bit per requester.
REQ-007 The block SHALL have port grant_valid, output, 1 bit, meaning a grant is presented.
REQ-008 The block SHALL have port grant_ready, input, 1 bit, meaning the consumer accepts the grant.
REQ-009 The block SHALL have port grant_bin, output, BinWidth bits, meaning the winner index.
REQ-010 The block SHALL have port grant_onehot, output, NumRequesters bits, meaning the one-hot decode of grant_bin, qualified by grant_valid.
REQ-011 The block SHALL have port grant_last, output, 1 bit, meaning this grant ends the winner's burst.

Function
REQ-012 The block SHALL register all outputs, so a request first visible in cycle t yields grant_valid in cycle t+1 at the earliest.
REQ-013 The block SHALL use a two-state FSM: IDLE (grant_valid=0) and GRANT (grant_valid=1).
REQ-014 In IDLE, when req is nonzero, the block SHALL select the first set bit at or after rr_ptr (circular search, wrapping from NumRequesters-1 to 0) and move to GRANT.
REQ-015 In GRANT with grant_ready=0, grant_bin, grant_onehot and grant_last SHALL hold stable, regardless of req changes, including withdrawal of the winner's request.
REQ-016 On acceptance (grant_valid & grant_ready), if grant_last=0 and req[winner]=1 in the same cycle, the block SHALL re-grant the same winner in the next cycle with burst_cnt incremented; no bubble is allowed.
REQ-017 On acceptance with grant_last=1, or with the winner's request deasserted, the block SHALL set rr_ptr to (winner+1) mod NumRequesters and reset burst_cnt to 0.
REQ-018 In the acceptance cycle the block SHALL arbitrate among the current req using the updated pointer: it stays in GRANT if any request is present, otherwise it goes to IDLE.
REQ-019 grant_last SHALL be 1 when burst_cnt equals MaxBurst-1; with MaxBurst=1 it is always 1.
REQ-020 burst_cnt SHALL be $clog2(MaxBurst+1) bits wide and SHALL never exceed MaxBurst-1.
REQ-021 grant_onehot SHALL be zero whenever grant_valid=0, and SHALL have exactly one bit set whenever grant_valid=1.
REQ-022 A request bit at or above NumRequesters SHALL be impossible by construction; an integration assertion SHALL check grant_bin < NumRequesters.

Reset
REQ-023 While rst=1 the block SHALL hold FSM=IDLE, rr_ptr=0, burst_cnt=0, grant_valid=0, grant_bin=0, grant_onehot=0 and grant_last=0.
REQ-024 An rst assertion in GRANT SHALL drop the pending grant immediately and asynchronously; arbitration resumes from requester 0 in the first cycle after rst deasserts.

Configuration
REQ-025 When macro BR_SCHED_RR_BIN_STALL_CNT_EN is defined, the block SHALL add output port stall_cnt, 16 bits, which saturates at 16'hFFFF and is cleared by rst.
REQ-026 With the macro defined, stall_cnt SHALL increment on each cycle with grant_valid=1 and grant_ready=0.
REQ-027 Without the macro, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package br_sched_pkg SHALL hold the FSM state enum (SchedIdle, SchedGrant) and the stall counter width constant (16).
REQ-029 grant_onehot SHALL be produced by one instance of sub-module br_enc_bin2onehot, driven by the registered grant_bin with in_valid=grant_valid.
REQ-030 Static assertions SHALL check NumRequesters>=2, MaxBurst>=1 and BinWidth>=$clog2(NumRequesters).

Verification
REQ-031 Reset test: N=4, rst pulsed mid-GRANT -> the next cycle shows grant_valid=0 and onehot=0; with req=4'b1000 after release, grant_bin=3 one cycle later.
REQ-032 Round-robin test: N=4, MaxBurst=1, req=4'b1111, ready=1 -> grant_bin sequence 0,1,2,3,0 on consecutive cycles, with grant_last=1 throughout.
REQ-033 Burst test: N=4, MaxBurst=2, req=4'b0101, ready=1 -> grant_bin 0,0,2,2,0, with grant_last 0,1,0,1,0.
REQ-034 Backpressure test: grant to 1, ready=0 for 5 cycles, req[1] dropped in cycle 2 -> outputs are constant for all 5 cycles; after acceptance, rr_ptr=2.
REQ-035 Wrap and idle test: N=3, req=3'b001 with pointer at 2 -> grant 0; then req=0 -> IDLE, with grant_valid=0 in the cycle after acceptance.
REQ-036 Stall counter test (macro defined): 70000 consecutive stall cycles -> stall_cnt=16'hFFFF and holds that value.
